// File: rtl/put_in_order_collector.sv
// ---------------------------------------------------------------------------
// put_in_order_collector
//
// Re-orders results from n_inputs variable-delay lanes back into the
// round-robin dispatch order (item k was sent to lane k mod n_inputs).
// Each lane owns a small FIFO. A head pointer names the lane that owes the
// next in-order item. The head lane either pops its oldest buffered entry
// or, when its FIFO is empty, forwards a same-cycle result directly.
// At most one item is emitted per clock. Outputs are registered.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   up_vld     [n_inputs]        per-lane single-cycle result pulse
//   up_data    [n_inputs*width]  lane i data in bits [i*width +: width]
//   down_vld   one-cycle valid for the ordered output
//   down_data  [width]           ordered output data
//   err        sticky lane-overflow flag
//
// Build option
//   PUT_IN_ORDER_COLLECTOR_ERR_EN : when defined, builds overflow detection
//   and err is set on the clock after the first dropped push, staying set
//   until reset. When undefined, err is tied to 0. Overflowing pushes are
//   dropped in both builds.
// ---------------------------------------------------------------------------
module put_in_order_collector #(
    parameter int unsigned width      = 16,
    parameter int unsigned n_inputs   = 5,
    parameter int unsigned lane_depth = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [n_inputs-1:0]          up_vld,
    input  logic [n_inputs*width-1:0]    up_data,
    output logic                         down_vld,
    output logic [width-1:0]             down_data,
    output logic                         err
);

    localparam int unsigned HW = (n_inputs > 1) ? $clog2(n_inputs) : 1;
    localparam int unsigned PW = (lane_depth > 1) ? $clog2(lane_depth) : 1;
    localparam int unsigned CW = $clog2(lane_depth) + 1;

    localparam logic [HW-1:0] HEAD_LAST = HW'(n_inputs - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(lane_depth - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(lane_depth);

    // Per-lane FIFO state
    logic [width-1:0] mem_q    [n_inputs][lane_depth];
    logic [PW-1:0]    wr_ptr_q [n_inputs];
    logic [PW-1:0]    wr_ptr_d [n_inputs];
    logic [PW-1:0]    rd_ptr_q [n_inputs];
    logic [PW-1:0]    rd_ptr_d [n_inputs];
    logic [CW-1:0]    cnt_q    [n_inputs];
    logic [CW-1:0]    cnt_d    [n_inputs];

    logic [HW-1:0]    head_q, head_d;
    logic             down_vld_q, down_vld_d;
    logic [width-1:0] down_data_q, down_data_d;

    logic [n_inputs-1:0] head_sel;
    logic [n_inputs-1:0] full;
    logic [n_inputs-1:0] push;
    logic [n_inputs-1:0] pop;
    logic                head_has;
    logic                bypass;
    logic                emit;
    logic [width-1:0]    emit_data;

    // Wrap on the last entry rather than relying on natural overflow so that
    // lane_depth = 1 keeps its single pointer pinned at 0.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        head_sel = '0;
        full     = '0;
        for (int unsigned i = 0; i < n_inputs; i++) begin
            head_sel[i] = (HW'(i) == head_q);
            full[i]     = (cnt_q[i] == CNT_FULL);
        end

        head_has  = (cnt_q[head_q] != '0);
        bypass    = !head_has && up_vld[head_q];
        emit      = head_has || bypass;
        emit_data = head_has ? mem_q[head_q][rd_ptr_q[head_q]]
                             : up_data[head_q*width +: width];

        pop = head_sel & {n_inputs{head_has}};

        // A bypassed result is never stored. A push into a full FIFO only
        // lands when the same lane pops this cycle; otherwise it is dropped.
        push = '0;
        for (int unsigned i = 0; i < n_inputs; i++) begin
            push[i] = up_vld[i] && !(head_sel[i] && bypass) && (!full[i] || pop[i]);
        end

        for (int unsigned i = 0; i < n_inputs; i++) begin
            cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
        end

        head_d = head_q;
        if (emit) begin
            head_d = (head_q == HEAD_LAST) ? '0 : head_q + HW'(1);
        end

        down_vld_d  = emit;
        down_data_d = emit ? emit_data : down_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            down_vld_q  <= 1'b0;
            down_data_q <= '0;
            for (int unsigned i = 0; i < n_inputs; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            head_q      <= head_d;
            down_vld_q  <= down_vld_d;
            down_data_q <= down_data_d;
            for (int unsigned i = 0; i < n_inputs; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    // FIFO storage carries no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < n_inputs; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= up_data[i*width +: width];
            end
        end
    end

    assign down_vld  = down_vld_q;
    assign down_data = down_data_q;

`ifdef PUT_IN_ORDER_COLLECTOR_ERR_EN
    logic [n_inputs-1:0] drop;
    logic                err_q, err_d;

    always_comb begin
        drop = '0;
        for (int unsigned i = 0; i < n_inputs; i++) begin
            drop[i] = up_vld[i] && full[i] && !pop[i];
        end
        err_d = err_q | (|drop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
